div_ctrl: RTL and testbench

//  Multi-cycle sequencer for DIV/DIVU in the multicycle CPU. Replaces the single-cycle

---
 rtl/div_ctrl.sv | 157 +++++++++++++++
 tb/tb_div_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl -- multi-cycle DIV/DIVU sequencer for the multicycle CPU.
//
// Restoring shift-subtract divider that resolves one quotient bit per clock.
// The control-unit FSM raises start for a cycle in IDLE. When the result is
// ready it sees a one-cycle done pulse. The remainder goes to HI and the
// quotient goes to LO.
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   reset        synchronous, active-high; returns the block to IDLE
//   start        request a divide; sampled only in IDLE
//   is_signed    1 = DIV (two's complement), 0 = DIVU
//   dividend     numerator, sampled with start
//   divisor      denominator, sampled with start
//   busy         high while iterating (CALC) and during sign fix-up (FIX)
//   done         one-cycle pulse; hi/lo/div_by_zero are valid in that cycle
//   div_by_zero  set with done when divisor was zero; held until next accepted start
//   hi           remainder (takes the sign of the dividend)
//   lo           quotient (truncated toward zero)
//
// Latency: accept at edge T, done visible after edge T+WIDTH+1.
// A divide by zero shows done after edge T.

module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  // Datapath registers. They are loaded on accept and need no reset.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;
  logic             accept;
  logic             div_zero_in;

  // Magnitude of an operand. In signed mode, -2^(W-1) maps to 2^(W-1),
  // which still fits in W unsigned bits.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic sgn);
    if (sgn && v[WIDTH-1])
      return -v;
    else
      return v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic neg);
    return neg ? -v : v;
  endfunction

  assign div_zero_in = (divisor == '0);
  assign accept      = (state == IDLE) && start;

  // Iteration step: shift the next dividend bit into the W+1 bit partial
  // remainder, then trial-subtract. When rem_ge holds, the difference is
  // below 2^W, so the low W bits of the subtraction are exact.
  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, dvs});
    rem_diff = rem_sh[WIDTH-1:0] - dvs;
  end

  // Control and architectural outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (div_zero_in) begin
              // No iterations: hand back the raw dividend as the remainder.
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              lo          <= '0;
              hi          <= dividend;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              count       <= '0;
            end
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          lo    <= apply_sign(quo, neg_q);
          hi    <= apply_sign(rem, neg_r);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture and iteration
  always_ff @(posedge clk) begin
    if (accept && !div_zero_in) begin
      rem   <= '0;
      quo   <= mag(dividend, is_signed);
      dvs   <= mag(divisor, is_signed);
      neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r <= is_signed & dividend[WIDTH-1];
    end else if (state == CALC) begin
      rem <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], rem_ge};
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl -- directed bench for div_ctrl (WIDTH = 32).
// Each step drives one operation and compares the outputs with hand-computed
// values.

module tb_div_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int vectors;
  int miscompares;

  div_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1 ns past it before any sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle, then wait for done with a bounded cycle count.
  // lat counts edges from the accepting edge to the edge after which done is seen.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input logic [W-1:0] exp_lo,
                         input logic [W-1:0] exp_hi, input logic exp_dz, input int exp_lat);
    int lat;
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    tick();
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    lat      = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " lo"}, lo, exp_lo);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " dz"}, {31'd0, div_by_zero}, {31'd0, exp_dz});
    chk({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    tick();
    chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
    chk({tag, " lo held"}, lo, exp_lo);
    chk({tag, " hi held"}, hi, exp_hi);
  endtask

  initial begin
    int lat;
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    is_signed   = 1'b0;
    dividend    = '0;
    divisor     = '0;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset dz", {31'd0, div_by_zero}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    run_div("divu 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
    run_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    run_div("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    run_div("div -7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);
    run_div("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_div("divu max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);
    run_div("divu 5/9", 32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 34);

    // Divide by zero: one-cycle latency, raw dividend in hi, flag held.
    run_div("divu dz", 32'h0000_1234, 32'd0, 1'b0, 32'd0, 32'h0000_1234, 1'b1, 1);
    tick();
    chk("dz flag held", {31'd0, div_by_zero}, 32'd1);
    run_div("div dz neg", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'd0, 32'hFFFF_FFF9, 1'b1, 1);
    run_div("dz cleared", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);

    // A new start at cycle 5 of CALC must be ignored.
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd9;
    tick();
    start = 1'b0;
    lat   = 1;
    repeat (4) begin
      tick();
      lat++;
    end
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    tick();
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    chk("busy start latency", lat, 34);
    chk("busy start lo", lo, 32'd111);
    chk("busy start hi", hi, 32'd1);

    // start while in DONE is ignored as well.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done start ignored busy", {31'd0, busy}, 32'd0);
    tick();
    chk("done start ignored done", {31'd0, done}, 32'd0);

    // Reset at cycle 10 of CALC together with start: reset wins, no done.
    start     = 1'b1;
    is_signed = 1'b1;
    dividend  = 32'hFFFF_FF00;
    divisor   = 32'd3;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    done_seen = 0;
    repeat (40) begin
      tick();
      if (done) done_seen++;
    end
    chk("abort no done", done_seen, 0);
    run_div("after abort", 32'hFFFF_FC18, 32'd10, 1'b1, 32'hFFFF_FF9C, 32'd0, 1'b0, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
